leds_ctrl: RTL and testbench

Parametrised memory-mapped LED output controller on the MMIO bus, driving up to 32 LEDs. Beyond static write-through of LED bits it adds a per-LED blink mask with a programmable blink period, a global PWM brightness duty and a read-back path. It is selected by the LED chip-select decoded in memorio and replaces the fixed 24-LED, write-only controller.

---
 rtl/leds_pkg.sv | 22 ++
 rtl/leds_timebase.sv | 77 +++++++
 rtl/leds_ctrl.sv | 134 +++++++++++++
 tb/tb_leds_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/leds_pkg.sv
// Shared definitions for the LED controller: register offsets, CTRL bit index
// and register reset values.
package leds_pkg;

    typedef enum logic [2:0] {
        LED_DATA_LO  = 3'd0,
        LED_DATA_HI  = 3'd1,
        LED_BLINK_LO = 3'd2,
        LED_BLINK_HI = 3'd3,
        LED_DUTY     = 3'd4,
        LED_PERIOD   = 3'd5,
        LED_CTRL     = 3'd6,
        LED_STATUS   = 3'd7
    } led_reg_e;

    localparam int unsigned LED_CTRL_EN = 0;

    localparam logic [15:0] LED_PERIOD_RST = 16'd500;
    // Truncated to PWM_BITS at the point of use, giving an all-ones duty.
    localparam logic [15:0] LED_DUTY_RST   = 16'hFFFF;

endpackage

// File: rtl/leds_timebase.sv
// Blink prescaler, blink counter/phase and PWM counter for leds_ctrl.
// PWM counter exists only when LEDS_PWM_EN is defined; otherwise pwm_on is 1.
module leds_timebase
    import leds_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 50000
`ifdef LEDS_PWM_EN
    ,
    parameter int unsigned PWM_BITS  = 8
`endif
) (
    input  logic                led_clk,
    input  logic                ledrst,
    input  logic                per_wr,
    input  logic [15:0]         period,
`ifdef LEDS_PWM_EN
    input  logic [PWM_BITS-1:0] duty,
`endif
    output logic                phase,
    output logic                pwm_on
);

    localparam int unsigned PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic          tick;
    logic [15:0]   bcnt_q;
    logic          phase_q;

    assign tick  = (presc_q == PW'(PRESC_DIV - 1));
    assign phase = phase_q;

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // A PERIOD write restarts the blink half-period even if a tick coincides.
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (per_wr || (period == 16'd0)) begin
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else if (tick) begin
            if (bcnt_q == period - 16'd1) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q  <= bcnt_q + 16'd1;
            end
        end
    end

`ifdef LEDS_PWM_EN
    logic [PWM_BITS-1:0] pcnt_q;

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    assign pwm_on = (duty == '1) || (pcnt_q < duty);
`else
    assign pwm_on = 1'b1;
`endif

endmodule

// File: rtl/leds_ctrl.sv
// Memory-mapped LED controller: static data, per-LED blink, global PWM duty, read-back.
// Define LEDS_PWM_EN to include the PWM counter and DUTY register.
module leds_ctrl
    import leds_pkg::*;
#(
    parameter int unsigned LED_W     = 24,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned PRESC_DIV = 50000
) (
    input  logic             led_clk,
    input  logic             ledrst,
    input  logic             ledcs,
    input  logic             ledwrite,
    input  logic             ledread,
    input  logic [3:0]       ledaddr,
    input  logic [15:0]      ledwdata,
    output logic [15:0]      ledrdata,
    output logic [LED_W-1:0] ledout
);

    led_reg_e            sel;
    logic                wr;
    logic                wr_dlo, wr_dhi, wr_blo, wr_bhi;
    logic                per_wr;
    logic [LED_W-1:0]    data_q, data_d;
    logic [LED_W-1:0]    blink_q, blink_d;
    logic [LED_W-1:0]    led_d;
    logic [PWM_BITS-1:0] duty_q;
    logic [15:0]         period_q;
    logic                en_q;
    logic                phase;
    logic                pwm_on;
    logic [31:0]         data_ext, blink_ext;
    logic [15:0]         rd_mux;
    logic                unused_addr0;

    assign sel          = led_reg_e'(ledaddr[3:1]);
    assign unused_addr0 = ledaddr[0];
    assign wr           = ledcs && ledwrite;
    assign wr_dlo       = wr && (sel == LED_DATA_LO);
    assign wr_dhi       = wr && (sel == LED_DATA_HI);
    assign wr_blo       = wr && (sel == LED_BLINK_LO);
    assign wr_bhi       = wr && (sel == LED_BLINK_HI);
    assign per_wr       = wr && (sel == LED_PERIOD);

    // Per-bit merge so LED bits beyond LED_W simply do not exist.
    always_comb begin
        data_d  = data_q;
        blink_d = blink_q;
        for (int unsigned i = 0; i < LED_W; i++) begin
            if (i < 16) begin
                if (wr_dlo) data_d[i]  = ledwdata[i[3:0]];
                if (wr_blo) blink_d[i] = ledwdata[i[3:0]];
            end else begin
                if (wr_dhi) data_d[i]  = ledwdata[i[3:0]];
                if (wr_bhi) blink_d[i] = ledwdata[i[3:0]];
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            led_d[i] = en_q & data_q[i] & (blink_q[i] ? phase : 1'b1) & pwm_on;
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            data_q   <= '0;
            blink_q  <= '0;
            period_q <= LED_PERIOD_RST;
            en_q     <= 1'b1;
            ledout   <= '0;
        end else begin
            data_q  <= data_d;
            blink_q <= blink_d;
            ledout  <= led_d;
            if (per_wr) period_q <= ledwdata;
            if (wr && (sel == LED_CTRL)) en_q <= ledwdata[LED_CTRL_EN];
        end
    end

`ifdef LEDS_PWM_EN
    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            duty_q <= LED_DUTY_RST[PWM_BITS-1:0];
        end else if (wr && (sel == LED_DUTY)) begin
            duty_q <= ledwdata[PWM_BITS-1:0];
        end
    end
`else
    assign duty_q = '0;
`endif

    leds_timebase #(
        .PRESC_DIV (PRESC_DIV)
`ifdef LEDS_PWM_EN
        ,
        .PWM_BITS  (PWM_BITS)
`endif
    ) u_timebase (
        .led_clk (led_clk),
        .ledrst  (ledrst),
        .per_wr  (per_wr),
        .period  (period_q),
`ifdef LEDS_PWM_EN
        .duty    (duty_q),
`endif
        .phase   (phase),
        .pwm_on  (pwm_on)
    );

    assign data_ext  = 32'(data_q);
    assign blink_ext = 32'(blink_q);

    always_comb begin
        rd_mux = '0;
        case (sel)
            LED_DATA_LO:  rd_mux = data_ext[15:0];
            LED_DATA_HI:  rd_mux = data_ext[31:16];
            LED_BLINK_LO: rd_mux = blink_ext[15:0];
            LED_BLINK_HI: rd_mux = blink_ext[31:16];
            LED_DUTY:     rd_mux = 16'(duty_q);
            LED_PERIOD:   rd_mux = period_q;
            LED_CTRL:     rd_mux[LED_CTRL_EN] = en_q;
            LED_STATUS:   rd_mux = {14'd0, pwm_on, phase};
            default:      rd_mux = '0;
        endcase
    end

    assign ledrdata = (ledcs && ledread) ? rd_mux : '0;

endmodule

// File: tb/tb_leds_ctrl.sv
// Self-checking bench for leds_ctrl: directed steps plus random bus traffic,
// checked against a time-arithmetic model of the LED behaviour.
module tb_leds_ctrl;

    localparam int unsigned LW   = 24;
    localparam int unsigned B    = 4;
    localparam int unsigned P    = 4;
    localparam int unsigned PCYC = 16;
    localparam int unsigned DMAX = 15;
    localparam logic [31:0] MASK = 32'h00FF_FFFF;

    logic          led_clk  = 1'b0;
    logic          ledrst   = 1'b1;
    logic          ledcs    = 1'b0;
    logic          ledwrite = 1'b0;
    logic          ledread  = 1'b0;
    logic [3:0]    ledaddr  = '0;
    logic [15:0]   ledwdata = '0;
    logic [15:0]   ledrdata;
    logic [LW-1:0] ledout;

    int checks   = 0;
    int failures = 0;

    // Model state: register contents, edges since reset release, last PERIOD write edge.
    int unsigned   m, anchor, mper, mduty;
    logic [31:0]   md, mb;
    bit            men;
    logic [LW-1:0] exp_led;

    leds_ctrl #(.LED_W(LW), .PWM_BITS(B), .PRESC_DIV(P)) dut (
        .led_clk  (led_clk),
        .ledrst   (ledrst),
        .ledcs    (ledcs),
        .ledwrite (ledwrite),
        .ledread  (ledread),
        .ledaddr  (ledaddr),
        .ledwdata (ledwdata),
        .ledrdata (ledrdata),
        .ledout   (ledout)
    );

    always #5 led_clk = ~led_clk;

    // Blink ticks fall on edges that are multiples of P; a toggle every mper ticks.
    function automatic bit m_phase();
        int unsigned ticks;
        if (mper == 0) return 1'b1;
        ticks = m / P - anchor / P;
        return ((ticks / mper) % 2) == 0;
    endfunction

    function automatic bit m_pwm();
`ifdef LEDS_PWM_EN
        return (mduty == DMAX) || ((m % PCYC) < mduty);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [LW-1:0] m_led();
        logic [LW-1:0] v;
        bit ph, pw;
        ph = m_phase();
        pw = m_pwm();
        for (int i = 0; i < LW; i++)
            v[i] = men && md[i] && (mb[i] ? ph : 1'b1) && pw;
        return v;
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return md[15:0];
            3'd1:    return md[31:16];
            3'd2:    return mb[15:0];
            3'd3:    return mb[31:16];
            3'd4:    return 16'(mduty);
            3'd5:    return 16'(mper);
            3'd6:    return {15'd0, men};
            default: return {14'd0, m_pwm(), m_phase()};
        endcase
    endfunction

    task automatic m_write(input logic [2:0] a, input logic [15:0] d);
        case (a)
            3'd0: begin md[15:0]  = d; md = md & MASK; end
            3'd1: begin md[31:16] = d; md = md & MASK; end
            3'd2: begin mb[15:0]  = d; mb = mb & MASK; end
            3'd3: begin mb[31:16] = d; mb = mb & MASK; end
`ifdef LEDS_PWM_EN
            3'd4: mduty = 32'(d) & DMAX;
`endif
            3'd5: begin mper = 32'(d); anchor = m; end
            3'd6: men = d[0];
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m = 0; anchor = 0; md = '0; mb = '0; mper = 500; men = 1'b1;
`ifdef LEDS_PWM_EN
        mduty = DMAX;
`else
        mduty = 0;
`endif
        exp_led = '0;
    endtask

    // One bus cycle, entered just after a falling edge.
    task automatic cycle(input bit cs, input bit wr, input bit rd,
                         input logic [2:0] a, input logic [15:0] d);
        logic [15:0] exp_rd;
        ledcs = cs; ledwrite = wr; ledread = rd; ledwdata = d;
        ledaddr = {a, 1'($urandom_range(0, 1))};
        #1;
        exp_rd = (cs && rd) ? m_read(a) : 16'h0000;
        checks++;
        assert (ledrdata === exp_rd) else begin
            failures++;
            $error("FAIL rdata a=%0d m=%0d: got %h expected %h", a, m, ledrdata, exp_rd);
        end
        exp_led = m_led();
        @(posedge led_clk);
        m++;
        if (cs && wr) m_write(a, d);
        @(negedge led_clk);
        checks++;
        assert (ledout === exp_led) else begin
            failures++;
            $error("FAIL ledout m=%0d: got %h expected %h", m, ledout, exp_led);
        end
    endtask

    task automatic wreg(input logic [2:0] a, input logic [15:0] d);
        cycle(1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic rreg(input logic [2:0] a);
        cycle(1'b1, 1'b0, 1'b1, a, 16'h0000);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    initial begin
        logic [15:0] rd;
        m_reset();
        #2;
        checks++;
        assert (ledout === '0) else begin
            failures++;
            $error("FAIL reset_ledout: got %h expected 0", ledout);
        end
        @(negedge led_clk);
        @(negedge led_clk);
        ledrst = 1'b0;
        m_reset();

        // Reset values
        rreg(3'd4); rreg(3'd5); rreg(3'd6); rreg(3'd7); rreg(3'd0);

        // Static write-through and out-of-range bits
        wreg(3'd0, 16'hA5A5);
        wreg(3'd1, 16'h00FF);
        idle(1);
        checks++;
        assert (ledout === 24'hFFA5A5) else begin
            failures++;
            $error("FAIL static_led: got %h expected ffa5a5", ledout);
        end
        rreg(3'd1);
        wreg(3'd1, 16'hFFFF);
        rreg(3'd1);

        // Blink on LED0 with PERIOD=3, then PERIOD=0
        wreg(3'd1, 16'h0000);
        wreg(3'd0, 16'h0001);
        wreg(3'd2, 16'h0001);
        wreg(3'd5, 16'd3);
        idle(40);
        rreg(3'd7);
        wreg(3'd5, 16'd0);
        idle(20);

        // PWM duty settings
        wreg(3'd2, 16'h0000);
        wreg(3'd4, 16'd4);
        idle(32);
        rreg(3'd4);
        wreg(3'd4, 16'd0);
        idle(16);
        rreg(3'd7);
        wreg(3'd4, 16'd15);
        idle(16);

        // Enable off/on, and read concurrent with write
        wreg(3'd6, 16'h0000);
        idle(2);
        rreg(3'd0);
        rreg(3'd6);
        wreg(3'd6, 16'h0001);
        cycle(1'b1, 1'b1, 1'b1, 3'd0, 16'h5A5A);
        rreg(3'd0);
        wreg(3'd7, 16'hFFFF);
        rreg(3'd7);

        // Random bus traffic
        for (int i = 0; i < 700; i++) begin
            logic [2:0]  a;
            logic [15:0] d;
            bit cs, wr, rdb;
            a = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            if (a == 3'd5) d = 16'($urandom_range(0, 5));
            if (a == 3'd6) d[0] = ($urandom_range(0, 3) != 0);
            cs  = ($urandom_range(0, 7) != 0);
            wr  = ($urandom_range(0, 9) < 4);
            rdb = ($urandom_range(0, 1) != 0);
            cycle(cs, wr, rdb, a, d);
        end

        // Asynchronous reset in the middle of blinking
        wreg(3'd6, 16'h0001);
        wreg(3'd4, 16'hFFFF);
        wreg(3'd0, 16'hFFFF);
        wreg(3'd2, 16'h00F0);
        wreg(3'd5, 16'd2);
        idle(13);
        #2;
        ledrst = 1'b1; ledcs = 1'b1; ledread = 1'b1; ledwrite = 1'b0; ledaddr = 4'd0;
        #1;
        checks++;
        assert (ledout === '0) else begin
            failures++;
            $error("FAIL async_rst_ledout: got %h expected 0", ledout);
        end
        rd = ledrdata;
        checks++;
        assert (rd === 16'h0000) else begin
            failures++;
            $error("FAIL async_rst_rdata: got %h expected 0000", rd);
        end
        @(negedge led_clk);
        @(negedge led_clk);
        ledrst = 1'b0;
        m_reset();
        rreg(3'd4); rreg(3'd5); rreg(3'd0);
        wreg(3'd0, 16'h1234);
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
